// File: rtl/reg_scoreboard_if.sv
// ============================================================================
// Module      : reg_scoreboard_if
// Description : Decode/writeback signal bundle between the pipeline and the
//               register scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_scoreboard_if #(
  parameter int REG_PTR_SIZE = 4
);
  logic                    D_issue_valid;
  logic [REG_PTR_SIZE-1:0] D_src_ptr_0;
  logic [REG_PTR_SIZE-1:0] D_src_ptr_1;
  logic [REG_PTR_SIZE-1:0] D_src_ptr_2;
  logic [2:0]              D_src_used;
  logic                    D_wr_valid;
  logic [REG_PTR_SIZE-1:0] D_wr_ptr;
  logic                    W_wr_valid;
  logic [REG_PTR_SIZE-1:0] W_wr_ptr;
  logic                    D_stall;
  logic                    D_issue_accept;

  // Pipeline side: drives decode/writeback info, receives the hold.
  modport master (
    output D_issue_valid, D_src_ptr_0, D_src_ptr_1, D_src_ptr_2, D_src_used,
    output D_wr_valid, D_wr_ptr, W_wr_valid, W_wr_ptr,
    input  D_stall, D_issue_accept
  );

  modport slave (
    input  D_issue_valid, D_src_ptr_0, D_src_ptr_1, D_src_ptr_2, D_src_used,
    input  D_wr_valid, D_wr_ptr, W_wr_valid, W_wr_ptr,
    output D_stall, D_issue_accept
  );
endinterface

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register in-flight write counters that hold decode on
//               RAW hazards and destination-count saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_scoreboard #(
  parameter int REG_COUNT      = 16,
  parameter int REG_PTR_SIZE   = 4,
  parameter int CNT_SIZE       = 2,
  parameter int STALL_CNT_SIZE = 16
) (
  input  wire logic                      clk,
  input  wire logic                      reset_SB,
  input  wire logic                      flush,
  reg_scoreboard_if.slave                sb_if,
  output logic                           idle,
  output logic                           underflow_err,
  output logic [STALL_CNT_SIZE-1:0]      stall_cycles
);

  localparam int                        C_VIEW_SIZE = 2 ** REG_PTR_SIZE;
  localparam logic [CNT_SIZE-1:0]       C_CNT_MAX   = '1;
  localparam logic [STALL_CNT_SIZE-1:0] C_STALL_MAX = '1;

  logic [CNT_SIZE-1:0]       cnt_q [REG_COUNT];
  logic [CNT_SIZE-1:0]       cnt_d [REG_COUNT];
  logic                      idle_q;
  logic                      idle_d;
  logic                      underflow_q;
  logic                      underflow_d;
  logic [STALL_CNT_SIZE-1:0] stall_cnt_q;
  logic [STALL_CNT_SIZE-1:0] stall_cnt_d;

  logic [CNT_SIZE-1:0]       w_cnt_view [C_VIEW_SIZE];
  logic [REG_COUNT-1:0]      w_inc;
  logic [REG_COUNT-1:0]      w_dec;
  logic [2:0]                w_src_busy;
  logic                      w_src_hazard;
  logic                      w_dst_sat;
  logic                      w_stall;
  logic                      w_accept;

  // Pointers beyond REG_COUNT see a constant zero count, so they never hazard.
  generate
    for (genvar gi = 0; gi < C_VIEW_SIZE; gi++) begin : g_view
      if (gi < REG_COUNT) begin : g_real
        assign w_cnt_view[gi] = cnt_q[gi];
      end else begin : g_pad
        assign w_cnt_view[gi] = '0;
      end
    end
  endgenerate

  assign w_src_busy[0] = (w_cnt_view[sb_if.D_src_ptr_0] != '0);
  assign w_src_busy[1] = (w_cnt_view[sb_if.D_src_ptr_1] != '0);
  assign w_src_busy[2] = (w_cnt_view[sb_if.D_src_ptr_2] != '0);
  assign w_src_hazard  = |(sb_if.D_src_used & w_src_busy);
  assign w_dst_sat     = sb_if.D_wr_valid & (w_cnt_view[sb_if.D_wr_ptr] == C_CNT_MAX);

  // Counts are pre-update: a same-cycle writeback does not release the hold.
  assign w_stall  = sb_if.D_issue_valid & (w_src_hazard | w_dst_sat);
  assign w_accept = sb_if.D_issue_valid & ~w_stall;

  assign sb_if.D_stall        = w_stall;
  assign sb_if.D_issue_accept = w_accept;

  generate
    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_match
      assign w_inc[gi] = w_accept & sb_if.D_wr_valid &
                         (sb_if.D_wr_ptr == REG_PTR_SIZE'(gi));
      assign w_dec[gi] = sb_if.W_wr_valid & (sb_if.W_wr_ptr == REG_PTR_SIZE'(gi));
    end
  endgenerate

  always_comb begin
    underflow_d = underflow_q;
    for (int i = 0; i < REG_COUNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush) begin
        cnt_d[i] = '0;
      end else if (w_inc[i] && !w_dec[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_SIZE'(1);
      end else if (w_dec[i] && !w_inc[i]) begin
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - CNT_SIZE'(1);
        end else begin
          underflow_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    idle_d = 1'b1;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (cnt_d[i] != '0) begin
        idle_d = 1'b0;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (w_stall && (stall_cnt_q != C_STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_SIZE'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_SB) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        cnt_q[i] <= '0;
      end
      idle_q      <= 1'b1;
      underflow_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      idle_q      <= idle_d;
      underflow_q <= underflow_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign idle          = idle_q;
  assign underflow_err = underflow_q;
  assign stall_cycles  = stall_cnt_q;

endmodule

`default_nettype wire
